// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings and the arbiter state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_rr_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the bridge port.
interface ahb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  localparam int MW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]    m_req;
  logic [2*NUM_MASTERS-1:0]  m_trans;
  logic [AW*NUM_MASTERS-1:0] m_addr;
  logic [NUM_MASTERS-1:0]    m_write;
  logic [DW*NUM_MASTERS-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]    m_grant;
  logic [NUM_MASTERS-1:0]    m_ready;
  logic                      h_readyout;
  logic [1:0]                h_trans;
  logic [AW-1:0]             h_addr;
  logic                      h_write;
  logic [DW-1:0]             h_wdata;
  logic                      h_readyin;
  logic [MW-1:0]             h_master;

  // Arbiter side.
  modport slave (
    input  m_req, m_trans, m_addr, m_write, m_wdata, h_readyout,
    output m_grant, m_ready, h_trans, h_addr, h_write, h_wdata, h_readyin, h_master
  );

  // Environment side: masters plus bridge.
  modport master (
    output m_req, m_trans, m_addr, m_write, m_wdata, h_readyout,
    input  m_grant, m_ready, h_trans, h_addr, h_write, h_wdata, h_readyin, h_master
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 3,
  parameter int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] ptr,
  output logic [MW-1:0] winner,
  output logic          any_req
);

  // One extra bit so ptr + k never overflows before the modulo fold.
  logic [MW:0] idx;

  // Scan N positions in rotation order and keep the first hit.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, otherwise paths
    // that skip an assignment would infer a latch.
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (MW+1)'(k);
      if (idx >= (MW+1)'(N)) idx = idx - (MW+1)'(N);
      if (!any_req && req[idx[MW-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[MW-1:0];
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge port among several masters.
// Address phase follows the registered grant; write data follows one beat behind.
module ahb_rr_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input logic              h_clk,
  input logic              h_reset,
  ahb_rr_arbiter_if.slave  bus
);

  localparam int MW = $clog2(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [MW-1:0]          grant_idx_q, grant_idx_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [MW-1:0]          data_idx_q;
  logic                   data_valid_q;

  logic [1:0]    trans_a [NUM_MASTERS];
  logic [AW-1:0] addr_a  [NUM_MASTERS];
  logic [DW-1:0] wdata_a [NUM_MASTERS];

  logic                   owner_req;
  logic [1:0]             eff_trans;
  logic                   rearb;
  logic [MW-1:0]          winner;
  logic                   any_req;
  logic [NUM_MASTERS-1:0] data_oh;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign trans_a[g] = bus.m_trans[2*g +: 2];
    assign addr_a[g]  = bus.m_addr[AW*g +: AW];
    assign wdata_a[g] = bus.m_wdata[DW*g +: DW];
  end

  rr_pick #(.N(NUM_MASTERS), .MW(MW)) u_pick (
    .req     (bus.m_req),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Address-phase mux: owner drives the bridge, BUSY or a dropped request reads as IDLE.
  always_comb begin
    owner_req   = bus.m_req[grant_idx_q];
    eff_trans   = HTRANS_IDLE;
    bus.h_addr  = '0;
    bus.h_write = 1'b0;
    if (state_q == OWN) begin
      bus.h_addr  = addr_a[grant_idx_q];
      bus.h_write = bus.m_write[grant_idx_q];
      if (owner_req && trans_a[grant_idx_q] != HTRANS_BUSY) eff_trans = trans_a[grant_idx_q];
    end
    bus.h_trans   = eff_trans;
    bus.h_readyin = bus.h_readyout & eff_trans[1];
    // The grant is locked while the owner is mid-transfer with its request up.
    rearb = bus.h_readyout && (state_q == PARK || !owner_req || eff_trans == HTRANS_IDLE);
  end

  // Next-state: hand the bus to the next requester in rotation, or park on master 0.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    if (rearb) begin
      if (any_req) begin
        state_d          = OWN;
        grant_idx_d      = winner;
        grant_d          = '0;
        grant_d[winner]  = 1'b1;
        rr_ptr_d         = (winner == MW'(NUM_MASTERS-1)) ? '0 : winner + 1'b1;
      end else begin
        state_d     = PARK;
        grant_idx_d = '0;
        grant_d     = NUM_MASTERS'(1);
      end
    end
  end

  // Arbitration registers.
  always_ff @(posedge h_clk or posedge h_reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (h_reset) begin
      state_q     <= PARK;
      grant_idx_q <= '0;
      grant_q     <= NUM_MASTERS'(1);
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Data-phase owner advances with each accepted address beat.
  always_ff @(posedge h_clk or posedge h_reset) begin
    if (h_reset) begin
      data_idx_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (bus.h_readyout) begin
      data_idx_q   <= grant_idx_q;
      data_valid_q <= eff_trans[1];
    end
  end

  // Data-phase outputs and per-master ready.
  always_comb begin
    data_oh             = '0;
    data_oh[data_idx_q] = 1'b1;
    bus.h_wdata         = data_valid_q ? wdata_a[data_idx_q] : '0;
    bus.h_master        = data_idx_q;
    bus.m_grant         = grant_q;
    bus.m_ready         = (grant_q | data_oh) & {NUM_MASTERS{bus.h_readyout}};
  end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed bench for ahb_rr_arbiter with three masters and hand-computed expectations.
module tb_ahb_rr_arbiter;
  import ahb_pkg::*;

  logic h_clk = 1'b0;
  logic h_reset;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  ahb_rr_arbiter_if #(.NUM_MASTERS(3), .AW(32), .DW(32)) bus ();

  ahb_rr_arbiter #(.NUM_MASTERS(3), .AW(32), .DW(32)) dut (
    .h_clk   (h_clk),
    .h_reset (h_reset),
    .bus     (bus)
  );

  always #5 h_clk = ~h_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic [1:0] tr,
                       input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    bus.m_req[i]            = req;
    bus.m_trans[2*i +: 2]   = tr;
    bus.m_addr[32*i +: 32]  = addr;
    bus.m_write[i]          = wr;
    bus.m_wdata[32*i +: 32] = wd;
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic cyc();
    @(posedge h_clk);
    #1;
  endtask

  initial begin
    h_reset        = 1'b1;
    bus.h_readyout = 1'b1;
    bus.m_req      = '0;
    bus.m_trans    = '0;
    bus.m_addr     = '0;
    bus.m_write    = '0;
    bus.m_wdata    = '0;

    // Reset state.
    #3;
    check("rst_grant",   bus.m_grant,   3'b001);
    check("rst_trans",   bus.h_trans,   2'b00);
    check("rst_addr",    bus.h_addr,    32'h0);
    check("rst_wdata",   bus.h_wdata,   32'h0);
    check("rst_readyin", bus.h_readyin, 1'b0);
    check("rst_master",  bus.h_master,  2'd0);
    #5 h_reset = 1'b0;

    // Single NONSEQ write from m0.
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h8009_fe67, 1'b1, 32'hA5A5_0001);
    cyc();
    check("t1_grant",   bus.m_grant,   3'b001);
    check("t1_addr",    bus.h_addr,    32'h8009_fe67);
    check("t1_trans",   bus.h_trans,   2'b10);
    check("t1_write",   bus.h_write,   1'b1);
    check("t1_readyin", bus.h_readyin, 1'b1);
    check("t1_mready",  bus.m_ready,   3'b001);
    cyc();
    check("t1_wdata",  bus.h_wdata,  32'hA5A5_0001);
    check("t1_master", bus.h_master, 2'd0);
    set_m(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    #1;
    check("t1_idle_trans", bus.h_trans, 2'b00);
    cyc();
    check("t1_park_wdata", bus.h_wdata, 32'h0);
    check("t1_park_grant", bus.m_grant, 3'b001);

    // All three request at once straight out of reset.
    h_reset = 1'b1;
    #2 h_reset = 1'b0;
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h100, 1'b0, 32'h11);
    set_m(1, 1'b1, HTRANS_NONSEQ, 32'h200, 1'b0, 32'h22);
    set_m(2, 1'b1, HTRANS_NONSEQ, 32'h300, 1'b0, 32'h33);
    cyc();
    check("t2_g0",    bus.m_grant, 3'b001);
    check("t2_a0",    bus.h_addr,  32'h100);
    cyc();
    check("t2_d0",    bus.h_wdata,  32'h11);
    check("t2_hold0", bus.m_grant,  3'b001);
    set_m(0, 1'b0, HTRANS_IDLE, 32'h100, 1'b0, 32'h11);
    cyc();
    check("t2_g1",    bus.m_grant, 3'b010);
    check("t2_a1",    bus.h_addr,  32'h200);
    check("t2_t1",    bus.h_trans, 2'b10);
    cyc();
    check("t2_d1",    bus.h_wdata,  32'h22);
    check("t2_m1",    bus.h_master, 2'd1);
    set_m(1, 1'b0, HTRANS_IDLE, 32'h200, 1'b0, 32'h22);
    cyc();
    check("t2_g2",    bus.m_grant, 3'b100);
    check("t2_a2",    bus.h_addr,  32'h300);
    cyc();
    check("t2_d2",    bus.h_wdata,  32'h33);
    check("t2_m2",    bus.h_master, 2'd2);
    set_m(2, 1'b0, HTRANS_IDLE, 32'h300, 1'b0, 32'h33);
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h104, 1'b0, 32'h44);
    set_m(1, 1'b1, HTRANS_NONSEQ, 32'h204, 1'b0, 32'h55);
    cyc();
    check("t2_wrap_g0", bus.m_grant, 3'b001);
    check("t2_wrap_a0", bus.h_addr,  32'h104);
    cyc();
    set_m(0, 1'b0, HTRANS_IDLE, 32'h104, 1'b0, 32'h44);
    cyc();
    check("t2_wrap_g1", bus.m_grant, 3'b010);
    check("t2_wrap_a1", bus.h_addr,  32'h204);
    cyc();
    set_m(1, 1'b0, HTRANS_IDLE, 32'h204, 1'b0, 32'h55);
    cyc();
    check("t2_park_g", bus.m_grant, 3'b001);
    check("t2_park_t", bus.h_trans, 2'b00);

    // m0 burst of five beats; m2 waits until m0 goes IDLE.
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h8000_0001, 1'b1, 32'hB0);
    cyc();
    check("t3_g_b1", bus.m_grant, 3'b001);
    check("t3_a_b1", bus.h_addr,  32'h8000_0001);
    set_m(2, 1'b1, HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 32'hC2);
    cyc();
    for (int k = 2; k <= 5; k++) begin
      set_m(0, 1'b1, HTRANS_SEQ, 32'h8000_0000 + 32'(k), 1'b1, 32'hB0);
      #1;
      check("t3_g_burst", bus.m_grant, 3'b001);
      check("t3_a_burst", bus.h_addr,  32'h8000_0000 + 32'(k));
      cyc();
    end
    set_m(0, 1'b1, HTRANS_IDLE, 32'h8000_0005, 1'b1, 32'hB0);
    #1;
    check("t3_g_idle", bus.m_grant, 3'b001);
    check("t3_t_idle", bus.h_trans, 2'b00);
    cyc();
    check("t3_g_m2", bus.m_grant,  3'b100);
    check("t3_a_m2", bus.h_addr,   32'h2000_0000);
    check("t3_hm",   bus.h_master, 2'd0);
    set_m(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    cyc();
    check("t3_d_m2",  bus.h_wdata,  32'hC2);
    check("t3_hm_m2", bus.h_master, 2'd2);
    set_m(2, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    cyc();

    // Bridge stalls during an m1 SEQ beat while m0 is waiting.
    set_m(1, 1'b1, HTRANS_NONSEQ, 32'h4000_0000, 1'b1, 32'hD1);
    cyc();
    check("t4_g_m1", bus.m_grant, 3'b010);
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h5000_0000, 1'b0, 32'hD0);
    cyc();
    set_m(1, 1'b1, HTRANS_SEQ, 32'h4000_0004, 1'b1, 32'hD1);
    cyc();
    bus.h_readyout = 1'b0;
    #1;
    check("t4_readyin_stall", bus.h_readyin, 1'b0);
    check("t4_mready_stall",  bus.m_ready,   3'b000);
    for (int s = 0; s < 3; s++) begin
      cyc();
      check("t4_g_stall", bus.m_grant,  3'b010);
      check("t4_m_stall", bus.h_master, 2'd1);
      check("t4_a_stall", bus.h_addr,   32'h4000_0004);
    end
    bus.h_readyout = 1'b1;
    cyc();
    set_m(1, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    #1;
    check("t4_g_after", bus.m_grant, 3'b010);
    cyc();
    check("t4_g_m0", bus.m_grant, 3'b001);
    check("t4_a_m0", bus.h_addr,  32'h5000_0000);
    set_m(0, 1'b0, HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
    cyc();
    cyc();

    // Idle bus: parked on m0 with its NONSEQ masked.
    set_m(0, 1'b0, HTRANS_NONSEQ, 32'h7000_0000, 1'b0, 32'h0);
    for (int s = 0; s < 5; s++) begin
      cyc();
      check("t5_g",       bus.m_grant,   3'b001);
      check("t5_trans",   bus.h_trans,   2'b00);
      check("t5_readyin", bus.h_readyin, 1'b0);
    end

    // Reset in the middle of an m1 burst.
    set_m(1, 1'b1, HTRANS_NONSEQ, 32'h6000_0000, 1'b1, 32'hE1);
    cyc();
    check("t6_g_m1", bus.m_grant, 3'b010);
    set_m(1, 1'b1, HTRANS_SEQ,    32'h6000_0004, 1'b1, 32'hE1);
    set_m(0, 1'b1, HTRANS_NONSEQ, 32'h0A00_0000, 1'b0, 32'hE0);
    set_m(2, 1'b1, HTRANS_NONSEQ, 32'h0C00_0000, 1'b0, 32'hE2);
    cyc();
    check("t6_g_hold", bus.m_grant, 3'b010);
    #2 h_reset = 1'b1;
    #1;
    check("t6_rst_g",       bus.m_grant,   3'b001);
    check("t6_rst_trans",   bus.h_trans,   2'b00);
    check("t6_rst_addr",    bus.h_addr,    32'h0);
    check("t6_rst_wdata",   bus.h_wdata,   32'h0);
    check("t6_rst_readyin", bus.h_readyin, 1'b0);
    check("t6_rst_master",  bus.h_master,  2'd0);
    #2 h_reset = 1'b0;
    cyc();
    check("t6_first_g", bus.m_grant, 3'b001);
    check("t6_first_a", bus.h_addr,  32'h0A00_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Round-robin AHB-side arbiter that shares the single AHB_APB bridge slave port between NUM_MASTERS requesters.
- Selects one address-phase owner and muxes its h_trans/h_addr/h_write onto the bridge.
- Tracks the data-phase owner separately so h_wdata follows one cycle behind the address.
- Holds the grant for the whole of a NONSEQ/SEQ burst, and hands over only when the bridge signals h_readyout.

Parameters:
NUM_MASTERS, 3, number of requesting masters (2..8)
AW, 32, address width
DW, 32, write-data width
MW, $clog2(NUM_MASTERS), master index width (derived, do not override)

Ports:
h_clk  in  1  system clock, all state on rising edge
h_reset  in  1  asynchronous, active-high reset
m_req  in  NUM_MASTERS  per-master bus request
m_trans  in  2*NUM_MASTERS  per-master HTRANS (00 IDLE, 10 NONSEQ, 11 SEQ; 01 BUSY treated as IDLE)
m_addr  in  AW*NUM_MASTERS  per-master address
m_write  in  NUM_MASTERS  per-master write flag
m_wdata  in  DW*NUM_MASTERS  per-master write data (data phase)
m_grant  out  NUM_MASTERS  one-hot address-phase owner, registered
m_ready  out  NUM_MASTERS  per-master ready: h_readyout for owner and data-phase owner, else 0
h_readyout  in  1  bridge ready (transfer accepted / data phase done)
h_trans  out  2  to bridge
h_addr  out  AW  to bridge
h_write  out  1  to bridge
h_wdata  out  DW  to bridge, muxed by data-phase owner
h_readyin  out  1  to bridge: h_readyout AND h_trans[1]
h_master  out  MW  current data-phase owner index

Behaviour:
- Reset (async, immediate, also mid-burst):
  - grant_idx=0, m_grant=one-hot 0, data_idx=0, rr_ptr=0, parked=1.
  - h_trans=00, h_addr=0, h_write=0, h_wdata=0, h_readyin=0.
- Two states: PARK, OWN.
  - PARK: grant_idx=0; h_trans forced to 00 regardless of m_trans[0].
  - OWN: address outputs = grant_idx master's m_trans/m_addr/m_write. h_trans is forced to 00 if that master's m_req=0 or its m_trans=01.
- Re-arbitration point: a rising edge with h_readyout=1 AND (state==PARK OR owner m_req=0 OR owner effective h_trans==00).
  - Grant is never changed while the owner drives NONSEQ/SEQ with m_req=1. This is the burst lock.
  - At a re-arbitration point, the winner is the first i with m_req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS. Go to OWN with grant_idx=winner and rr_ptr=winner+1 (wraps NUM_MASTERS-1 -> 0). If no requester, go to PARK.
  - The current owner is eligible again only after all higher-rotation requesters.
- Latency: a request seen at a re-arbitration edge gives m_grant the next cycle. The master's address appears on h_addr that same cycle (combinational mux from the registered grant_idx).
- Data phase: on each rising edge with h_readyout=1, data_idx <= grant_idx and data_valid <= h_trans[1].
  - h_wdata = m_wdata[data_idx] when data_valid, else 0.
  - h_master = data_idx.
- h_readyout=0: grant_idx, data_idx, rr_ptr and state all hold. Address outputs keep following the owner, which must itself hold them.
- A simultaneous request from every master at an arbitration point is served strictly in rotation order from rr_ptr.
- A request dropped by a non-owner before it is granted has no effect.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS constants: HTRANS_IDLE=2'b00, HTRANS_BUSY=2'b01, HTRANS_NONSEQ=2'b10, HTRANS_SEQ=2'b11.
  - Arbiter state enum {PARK, OWN}.
- One sub-module: rr_pick (combinational).
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any_req.
  - Reused by future APB-side schedulers.

Test Plan:
- Only m0 requests; NONSEQ write to 32'h8009_fe67, wdata 32'hA5A5_0001, h_readyout=1 -> m_grant=001 next cycle; h_addr=32'h8009_fe67, h_trans=10, h_write=1; following cycle h_wdata=32'hA5A5_0001, h_master=0.
- m0, m1, m2 request simultaneously from reset, each doing single NONSEQ then IDLE -> grant order 0,1,2 then back to 0; rr_ptr wraps 2->0.
- m0 runs a burst (NONSEQ 32'h8000_0001 then SEQ 32'h8000_0002..0005) while m2 requests from beat 1 -> m_grant stays 001 for all 5 beats; switches to 100 on the edge after m0 drives IDLE.
- h_readyout held 0 for 3 cycles during an m1 SEQ beat with m0 requesting -> m_grant, h_master and h_addr unchanged; grant moves only after h_readyout returns to 1 and m1 goes IDLE.
- No requests for 5 cycles -> state PARK, m_grant=001, h_trans=00, h_readyin=0 throughout.
- h_reset pulsed high mid-burst of m1 -> outputs go IDLE/zero asynchronously; after release, first grant goes to the lowest-index requester.
